// File: rtl/loopback_pkg.sv
// loopback_pkg
//   Shared types and default sizing for the pin-loopback checker.
//   state_t  : checker FSM states
//   cmp_t    : result of one s1-vs-s2 sequence compare
//   *_DEF    : default widths and thresholds used by the modules
package loopback_pkg;

   localparam int unsigned PAT_W_DEF      = 15;
   localparam int unsigned SLOW_W_DEF     = 4;
   localparam int unsigned LOCK_COUNT_DEF = 4;
   localparam int unsigned LOSS_COUNT_DEF = 4;
   localparam int unsigned ERR_W_DEF      = 8;
   // Lock and loss thresholds are limited to 1..15.
   localparam int unsigned CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEEK   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   typedef enum logic {
      CMP_BAD  = 1'b0,
      CMP_GOOD = 1'b1
   } cmp_t;

endpackage

// File: rtl/loopback_cmp.sv
// loopback_cmp
//   Combinational sequence compare between the newest sample (s1) and the
//   one before it (s2). Good when the fast pattern stepped by exactly one
//   and the slow pattern stepped by one only on the fast-pattern wrap.
//   Ports:
//     i_s1_pat / i_s1_slow : newest captured sample
//     i_s2_pat / i_s2_slow : previous captured sample
//     o_result             : CMP_GOOD or CMP_BAD
module loopback_cmp
   import loopback_pkg::*;
#(
   parameter int unsigned PAT_W  = PAT_W_DEF,
   parameter int unsigned SLOW_W = SLOW_W_DEF
) (
   input  logic [PAT_W-1:0]  i_s1_pat,
   input  logic [PAT_W-1:0]  i_s2_pat,
   input  logic [SLOW_W-1:0] i_s1_slow,
   input  logic [SLOW_W-1:0] i_s2_slow,
   output cmp_t              o_result
);

   logic [PAT_W-1:0]  w_pat_exp;
   logic [SLOW_W-1:0] w_slow_exp;

   assign w_pat_exp  = i_s2_pat + {{(PAT_W-1){1'b0}}, 1'b1};
   // Slow pattern carries only when the fast pattern is wrapping.
   assign w_slow_exp = (&i_s2_pat) ? (i_s2_slow + {{(SLOW_W-1){1'b0}}, 1'b1})
                                   : i_s2_slow;

   always_comb begin
      o_result = CMP_BAD;
      if ((i_s1_pat == w_pat_exp) && (i_s1_slow == w_slow_exp))
         o_result = CMP_GOOD;
   end

endmodule

// File: rtl/loopback_checker.sv
// loopback_checker
//   Samples the looped-back counter pins, locks onto the incrementing
//   sequence and counts sequence violations seen while locked.
//   Ports:
//     clk        : sole clock
//     reset      : asynchronous active-low reset
//     enable     : checker enable (level); low forces IDLE
//     err_clear  : synchronous clear of err_count / err_sticky (wins over
//                  an error counted on the same edge)
//     pat_in     : looped-back fast pattern
//     slow_in    : looped-back slow pattern
//     locked     : high while in LOCKED
//     err_count  : saturating count of bad compares made while LOCKED
//     err_sticky : set by any counted error
//
//   state  | meaning
//   IDLE   | disabled or just reset; pipeline and lock/miss counters clear
//   SEEK   | counting consecutive good compares toward lock
//   LOCKED | counting errors and consecutive misses toward loss of lock
module loopback_checker
   import loopback_pkg::*;
#(
   parameter int unsigned PAT_W      = PAT_W_DEF,
   parameter int unsigned SLOW_W     = SLOW_W_DEF,
   parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
   parameter int unsigned LOSS_COUNT = LOSS_COUNT_DEF,
   parameter int unsigned ERR_W      = ERR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              err_clear,
   input  logic [PAT_W-1:0]  pat_in,
   input  logic [SLOW_W-1:0] slow_in,
   output logic              locked,
   output logic [ERR_W-1:0]  err_count,
   output logic              err_sticky
);

   localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_COUNT);

   logic [PAT_W-1:0]  r_s1_pat, r_s2_pat;
   logic [SLOW_W-1:0] r_s1_slow, r_s2_slow;
   logic [1:0]        r_valid;
   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_match, w_match_nxt, w_match_inc;
   logic [CNT_W-1:0]  r_miss, w_miss_nxt, w_miss_inc;
   logic [ERR_W-1:0]  r_err;
   logic              r_sticky;
   logic              r_locked;
   logic              w_cmp_valid;
   logic              w_count_err;
   cmp_t              w_cmp;

   loopback_cmp #(
      .PAT_W  (PAT_W),
      .SLOW_W (SLOW_W)
   ) u_cmp (
      .i_s1_pat  (r_s1_pat),
      .i_s2_pat  (r_s2_pat),
      .i_s1_slow (r_s1_slow),
      .i_s2_slow (r_s2_slow),
      .o_result  (w_cmp)
   );

   // Both stages must hold samples captured with enable high.
   assign w_cmp_valid = (r_valid == 2'b11);
   assign w_match_inc = r_match + 1'b1;
   assign w_miss_inc  = r_miss + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_pat  <= '0;
         r_s1_slow <= '0;
         r_s2_pat  <= '0;
         r_s2_slow <= '0;
         r_valid   <= '0;
      end else begin
         r_s1_pat  <= pat_in;
         r_s1_slow <= slow_in;
         r_s2_pat  <= r_s1_pat;
         r_s2_slow <= r_s1_slow;
         r_valid   <= enable ? {r_valid[0], 1'b1} : 2'b00;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = r_match;
      w_miss_nxt  = r_miss;
      w_count_err = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_match_nxt = '0;
         w_miss_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = SEEK;
               w_match_nxt = '0;
               w_miss_nxt  = '0;
            end
            SEEK: begin
               if (w_cmp_valid) begin
                  if (w_cmp == CMP_GOOD) begin
                     w_match_nxt = w_match_inc;
                     if (w_match_inc == LOCK_C) begin
                        w_state_nxt = LOCKED;
                        w_miss_nxt  = '0;
                     end
                  end else begin
                     w_match_nxt = '0;
                  end
               end
            end
            LOCKED: begin
               if (w_cmp_valid) begin
                  if (w_cmp == CMP_GOOD) begin
                     w_miss_nxt = '0;
                  end else begin
                     w_count_err = 1'b1;
                     w_miss_nxt  = w_miss_inc;
                     if (w_miss_inc == LOSS_C) begin
                        w_state_nxt = SEEK;
                        w_match_nxt = '0;
                        w_miss_nxt  = '0;
                     end
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_match_nxt = '0;
               w_miss_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_match  <= '0;
         r_miss   <= '0;
         r_locked <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_match  <= w_match_nxt;
         r_miss   <= w_miss_nxt;
         r_locked <= (w_state_nxt == LOCKED);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err    <= '0;
         r_sticky <= 1'b0;
      end else if (err_clear) begin
         r_err    <= '0;
         r_sticky <= 1'b0;
      end else if (w_count_err) begin
         if (r_err != {ERR_W{1'b1}})
            r_err <= r_err + 1'b1;
         r_sticky <= 1'b1;
      end
   end

   assign locked     = r_locked;
   assign err_count  = r_err;
   assign err_sticky = r_sticky;

endmodule

// File: tb/tb_loopback_checker.sv
module tb_loopback_checker;

   localparam int M_IDLE   = 0;
   localparam int M_SEEK   = 1;
   localparam int M_LOCKED = 2;
   localparam int LOCK_N   = 4;
   localparam int LOSS_N   = 4;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        err_clear;
   logic [14:0] pat_in;
   logic [3:0]  slow_in;
   logic        locked;
   logic [7:0]  err_count;
   logic        err_sticky;

   int total = 0;
   int bad   = 0;

   logic [14:0] tb_pat;
   logic [3:0]  tb_slow;

   // Reference model: remembers the samples captured during the current
   // enabled run and applies the sequence rules to the two most recent.
   int          m_mode;
   int          m_match, m_miss, m_err;
   bit          m_sticky, m_locked;
   logic [18:0] m_run[$];

   loopback_checker dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .err_clear  (err_clear),
      .pat_in     (pat_in),
      .slow_in    (slow_in),
      .locked     (locked),
      .err_count  (err_count),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want finish");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_mode = M_IDLE; m_match = 0; m_miss = 0; m_err = 0;
      m_sticky = 0; m_locked = 0; m_run.delete();
   endfunction

   function automatic void model_step(bit en, bit clr, int p, int s);
      int  cp, cs, pp, ps;
      bit  good;
      if (!en) begin
         m_mode = M_IDLE; m_match = 0; m_miss = 0; m_run.delete();
      end else if (m_mode == M_IDLE) begin
         m_mode = M_SEEK;
      end else if (m_run.size() == 2) begin
         cp = int'(m_run[1][18:4]); cs = int'(m_run[1][3:0]);
         pp = int'(m_run[0][18:4]); ps = int'(m_run[0][3:0]);
         good = (cp == (pp + 1) % 32768) &&
                (cs == ((pp == 32767) ? (ps + 1) % 16 : ps));
         if (m_mode == M_SEEK) begin
            m_match = good ? m_match + 1 : 0;
            if (m_match == LOCK_N) begin
               m_mode = M_LOCKED; m_miss = 0;
            end
         end else begin
            if (good) m_miss = 0;
            else begin
               m_miss++;
               if (m_err < 255) m_err++;
               m_sticky = 1;
               if (m_miss == LOSS_N) begin
                  m_mode = M_SEEK; m_match = 0; m_miss = 0;
               end
            end
         end
      end
      if (clr) begin
         m_err = 0; m_sticky = 0;
      end
      if (en) begin
         m_run.push_back({p[14:0], s[3:0]});
         if (m_run.size() > 2) void'(m_run.pop_front());
      end
      m_locked = (m_mode == M_LOCKED);
   endfunction

   task automatic cyc(input bit en, input bit clr, input logic [14:0] p, input logic [3:0] s);
      @(negedge clk);
      enable = en; err_clear = clr; pat_in = p; slow_in = s;
      @(posedge clk);
      model_step(en, clr, int'(p), int'(s));
      #1;
   endtask

   task automatic advance();
      if (tb_pat == 15'h7FFF) tb_slow = tb_slow + 4'd1;
      tb_pat = tb_pat + 15'd1;
   endtask

   task automatic ramp_step(input bit clr);
      cyc(1'b1, clr, tb_pat, tb_slow);
      advance();
   endtask

   task automatic start_ramp(input logic [14:0] p0, input logic [3:0] s0);
      cyc(1'b0, 1'b1, p0, s0);
      cyc(1'b0, 1'b0, p0, s0);
      tb_pat = p0; tb_slow = s0;
      repeat (7) ramp_step(1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; err_clear = 1'b0; pat_in = '0; slow_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({locked, err_count, err_sticky} !== 10'b0) begin
         bad++;
         $display("FAIL reset_outputs: got locked=%0b err=%0d sticky=%0b want all 0",
                  locked, err_count, err_sticky);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_clean_lock();
      int mx;
      bit st, lost;
      repeat (3) cyc(1'b0, 1'b0, 15'h0, 4'h0);
      tb_pat = 15'h0100; tb_slow = 4'd3;
      for (int k = 1; k <= 6; k++) begin
         ramp_step(1'b0);
         total++;
         if (locked !== (k >= 6)) begin
            bad++;
            $display("FAIL lock_edge_%0d: got locked=%0b want %0b", k, locked, k >= 6);
         end
      end
      mx = 0; st = 0; lost = 0;
      repeat (1000) begin
         ramp_step(1'b0);
         if (int'(err_count) > mx) mx = int'(err_count);
         if (err_sticky !== 1'b0) st = 1;
         if (locked !== 1'b1) lost = 1;
      end
      total++;
      if (mx !== 0 || st !== 0 || lost !== 0) begin
         bad++;
         $display("FAIL clean_run: got max_err=%0d sticky_seen=%0b lock_lost=%0b want 0 0 0",
                  mx, st, lost);
      end
   endtask

   task automatic test_glitch();
      start_ramp(15'h0100, 4'd3);
      while (tb_pat != 15'h0200) ramp_step(1'b0);
      cyc(1'b1, 1'b0, 15'h0A00, tb_slow);
      advance();
      repeat (3) ramp_step(1'b0);
      total++;
      if (err_count !== 8'd2 || err_sticky !== 1'b1 || locked !== 1'b1) begin
         bad++;
         $display("FAIL glitch: got err=%0d sticky=%0b locked=%0b want 2 1 1",
                  err_count, err_sticky, locked);
      end
   endtask

   task automatic test_wrap();
      start_ramp(15'h7FF0, 4'd5);
      while (tb_pat != 15'h0001) ramp_step(1'b0);
      repeat (2) ramp_step(1'b0);
      total++;
      if (err_count !== 8'd0 || locked !== 1'b1) begin
         bad++;
         $display("FAIL wrap_carry: got err=%0d locked=%0b want 0 1", err_count, locked);
      end
      start_ramp(15'h7FF4, 4'd5);
      while (tb_pat != 15'h0000) ramp_step(1'b0);
      cyc(1'b1, 1'b0, 15'h0000, 4'd5);
      cyc(1'b1, 1'b0, 15'h0001, 4'd5);
      total++;
      if (err_count !== 8'd1 || err_sticky !== 1'b1 || locked !== 1'b1) begin
         bad++;
         $display("FAIL wrap_no_carry: got err=%0d sticky=%0b locked=%0b want 1 1 1",
                  err_count, err_sticky, locked);
      end
      start_ramp(15'h7FF4, 4'd15);
      while (tb_pat != 15'h0003) ramp_step(1'b0);
      total++;
      if (err_count !== 8'd0 || locked !== 1'b1 || tb_slow !== 4'd0) begin
         bad++;
         $display("FAIL wrap_slow_wrap: got err=%0d locked=%0b want 0 1", err_count, locked);
      end
   endtask

   task automatic test_stuck();
      start_ramp(15'h0100, 4'd3);
      cyc(1'b1, 1'b0, 15'h1234, 4'd3);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b1, 1'b0, 15'h1234, 4'd3);
         total++;
         if (int'(err_count) !== k || locked !== (k < 4)) begin
            bad++;
            $display("FAIL stuck_%0d: got err=%0d locked=%0b want %0d %0b",
                     k, err_count, locked, k, k < 4);
         end
      end
      repeat (10) cyc(1'b1, 1'b0, 15'h1234, 4'd3);
      total++;
      if (err_count !== 8'd4 || locked !== 1'b0) begin
         bad++;
         $display("FAIL stuck_seek_hold: got err=%0d locked=%0b want 4 0", err_count, locked);
      end
   endtask

   task automatic test_clear_priority();
      start_ramp(15'h0300, 4'd9);
      repeat (3) begin
         cyc(1'b1, 1'b0, tb_pat ^ 15'h0A00, tb_slow);
         advance();
         repeat (3) ramp_step(1'b0);
      end
      advance();
      repeat (3) ramp_step(1'b0);
      total++;
      if (err_count !== 8'd7 || locked !== 1'b1) begin
         bad++;
         $display("FAIL clear_setup: got err=%0d locked=%0b want 7 1", err_count, locked);
      end
      advance();
      ramp_step(1'b0);
      ramp_step(1'b1);
      total++;
      if (err_count !== 8'd0 || err_sticky !== 1'b0 || locked !== 1'b1) begin
         bad++;
         $display("FAIL clear_wins: got err=%0d sticky=%0b locked=%0b want 0 0 1",
                  err_count, err_sticky, locked);
      end
      repeat (3) ramp_step(1'b0);
      total++;
      if (err_count !== 8'd0) begin
         bad++;
         $display("FAIL clear_after: got err=%0d want 0", err_count);
      end
   endtask

   task automatic test_saturation();
      start_ramp(15'h0100, 4'd7);
      for (int i = 0; i < 300; i++) begin
         advance();
         ramp_step(1'b0);
         ramp_step(1'b0);
         if (i == 253) begin
            total++;
            if (err_count !== 8'd254) begin
               bad++;
               $display("FAIL sat_254: got err=%0d want 254", err_count);
            end
         end
      end
      total++;
      if (err_count !== 8'd255 || err_sticky !== 1'b1 || locked !== 1'b1) begin
         bad++;
         $display("FAIL sat_255: got err=%0d sticky=%0b locked=%0b want 255 1 1",
                  err_count, err_sticky, locked);
      end
      cyc(1'b0, 1'b0, tb_pat, tb_slow);
      total++;
      if (err_count !== 8'd255 || locked !== 1'b0 || err_sticky !== 1'b1) begin
         bad++;
         $display("FAIL enable_drop: got err=%0d locked=%0b sticky=%0b want 255 0 1",
                  err_count, locked, err_sticky);
      end
      repeat (7) ramp_step(1'b0);
      total++;
      if (err_count !== 8'd255 || locked !== 1'b1) begin
         bad++;
         $display("FAIL relock_hold: got err=%0d locked=%0b want 255 1", err_count, locked);
      end
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      total++;
      if ({locked, err_count, err_sticky} !== 10'b0) begin
         bad++;
         $display("FAIL async_reset: got locked=%0b err=%0d sticky=%0b want all 0",
                  locked, err_count, err_sticky);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_random();
      bit en, clr;
      int kind;
      start_ramp(15'($urandom), 4'($urandom));
      repeat (3000) begin
         en   = ($urandom_range(0, 199) != 0);
         clr  = ($urandom_range(0, 63) == 0);
         kind = $urandom_range(0, 99);
         if (!en && $urandom_range(0, 1) == 1)
            tb_pat = 15'h7FF0;
         if (kind < 85) begin
            cyc(en, clr, tb_pat, tb_slow);
            advance();
         end else if (kind < 93) begin
            cyc(en, clr, 15'($urandom), tb_slow);
         end else begin
            advance();
            cyc(en, clr, tb_pat, tb_slow);
            advance();
         end
         total++;
         if (locked !== m_locked || int'(err_count) !== m_err || err_sticky !== m_sticky) begin
            bad++;
            $display("FAIL random: got locked=%0b err=%0d sticky=%0b want %0b %0d %0b",
                     locked, err_count, err_sticky, m_locked, m_err, m_sticky);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_glitch();
      test_wrap();
      test_stuck();
      test_clear_priority();
      test_saturation();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
